// File: rtl/uart_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the UART peripheral's single MMIO port.
// Serialises whole transactions and flags ones that outlive the watchdog bound.
module uart_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_read_i,
   input  logic        m0_write_i,
   input  logic [31:0] m0_address_i,
   input  logic [31:0] m0_write_data_i,
   output logic [31:0] m0_read_data_o,
   output logic        m0_response_o,
   input  logic        m1_read_i,
   input  logic        m1_write_i,
   input  logic [31:0] m1_address_i,
   input  logic [31:0] m1_write_data_i,
   output logic [31:0] m1_read_data_o,
   output logic        m1_response_o,
   output logic        uart_read_o,
   output logic        uart_write_o,
   output logic [31:0] uart_address_o,
   output logic [31:0] uart_write_data_o,
   input  logic [31:0] uart_read_data_i,
   input  logic        uart_response_i,
   output logic [1:0]  grant_o,
   output logic        busy_o,
   output logic        timeout_err_o
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

   state_e      state_q;
   logic        last_q;
   logic [1:0]  grant_q;
   logic [31:0] addr_q, wdata_q;
   logic        rd_stb_q, wr_stb_q;
   logic [31:0] m0_rdata_q, m1_rdata_q;
   logic        m0_resp_q, m1_resp_q;
   logic [31:0] cnt_q;
   logic        timeout_q;

   logic        req0, req1, win1, sel_write;
   logic [31:0] cnt_d;
   logic        wd_hit;

   assign req0 = m0_read_i | m0_write_i;
   assign req1 = m1_read_i | m1_write_i;
   // On contention the requester that did not win last time takes it.
   assign win1 = req1 & (~req0 | ~last_q);
   assign sel_write = win1 ? m1_write_i : m0_write_i;

   assign cnt_d  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
   assign wd_hit = (TIMEOUT_CYCLES != 0) && (cnt_d >= 32'(TIMEOUT_CYCLES));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         last_q     <= 1'b1;
         grant_q    <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_stb_q   <= 1'b0;
         wr_stb_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         m0_resp_q  <= 1'b0;
         m1_resp_q  <= 1'b0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
      end else begin
         rd_stb_q  <= 1'b0;
         wr_stb_q  <= 1'b0;
         m0_resp_q <= 1'b0;
         m1_resp_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req0 | req1) begin
                  last_q   <= win1;
                  grant_q  <= win1 ? 2'b10 : 2'b01;
                  addr_q   <= win1 ? m1_address_i : m0_address_i;
                  wdata_q  <= win1 ? m1_write_data_i : m0_write_data_i;
                  // Strobe is registered here so it is high for exactly the ISSUE cycle.
                  wr_stb_q <= sel_write;
                  rd_stb_q <= ~sel_write;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               cnt_q <= cnt_d;
               if (wd_hit) timeout_q <= 1'b1;
               if (uart_response_i) begin
                  if (grant_q[1]) begin
                     m1_rdata_q <= uart_read_data_i;
                     m1_resp_q  <= 1'b1;
                  end else begin
                     m0_rdata_q <= uart_read_data_i;
                     m0_resp_q  <= 1'b1;
                  end
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               grant_q <= 2'b00;
               state_q <= S_IDLE;
            end
            default: begin
               grant_q <= 2'b00;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign m0_read_data_o    = m0_rdata_q;
   assign m1_read_data_o    = m1_rdata_q;
   assign m0_response_o     = m0_resp_q;
   assign m1_response_o     = m1_resp_q;
   assign uart_read_o       = rd_stb_q;
   assign uart_write_o      = wr_stb_q;
   assign uart_address_o    = addr_q;
   assign uart_write_data_o = wdata_q;
   assign grant_o           = grant_q;
   assign busy_o            = (state_q != S_IDLE);
   assign timeout_err_o     = timeout_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter with a delayed-response peripheral model.
// Expected values are hand-derived from the transaction timing.
module tb_uart_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_read_i, m0_write_i, m1_read_i, m1_write_i;
   logic [31:0] m0_address_i, m0_write_data_i, m1_address_i, m1_write_data_i;
   logic [31:0] m0_read_data_o, m1_read_data_o;
   logic        m0_response_o, m1_response_o;
   logic        uart_read_o, uart_write_o;
   logic [31:0] uart_address_o, uart_write_data_o;
   logic [31:0] uart_read_data_i = '0;
   logic        uart_response_i = 1'b0;
   logic [1:0]  grant_o;
   logic        busy_o, timeout_err_o;

   int errors = 0;
   int checks = 0;

   // peripheral model controls (written by stimulus only)
   int          rsp_delay;
   logic [31:0] rsp_data;

   // model/monitor state (written by the model process only)
   int          cd = 0;
   int          cyc = 0;
   int          strobe_cnt = 0;
   int          m0_rc = 0, m1_rc = 0;
   bit          prev_busy = 1'b0;
   logic [31:0] wd_log [64];
   logic [31:0] ad_log [64];
   logic [1:0]  gr_log [64];
   logic [1:0]  op_log [64];
   int          cyc_log [64];
   bit          pb_log [64];

   int strobe_tgt;

   uart_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
      .m0_address_i(m0_address_i), .m0_write_data_i(m0_write_data_i),
      .m0_read_data_o(m0_read_data_o), .m0_response_o(m0_response_o),
      .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
      .m1_address_i(m1_address_i), .m1_write_data_i(m1_write_data_i),
      .m1_read_data_o(m1_read_data_o), .m1_response_o(m1_response_o),
      .uart_read_o(uart_read_o), .uart_write_o(uart_write_o),
      .uart_address_o(uart_address_o), .uart_write_data_o(uart_write_data_o),
      .uart_read_data_i(uart_read_data_i), .uart_response_i(uart_response_i),
      .grant_o(grant_o), .busy_o(busy_o), .timeout_err_o(timeout_err_o)
   );

   always #5 clk = ~clk;

   // Peripheral: responds rsp_delay cycles after the strobe cycle, one-cycle pulse.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      uart_response_i = 1'b0;
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            uart_response_i  = 1'b1;
            uart_read_data_i = rsp_data;
         end
      end
      if (uart_read_o | uart_write_o) begin
         if (strobe_cnt < 64) begin
            wd_log[strobe_cnt]  = uart_write_data_o;
            ad_log[strobe_cnt]  = uart_address_o;
            gr_log[strobe_cnt]  = grant_o;
            op_log[strobe_cnt]  = {uart_read_o, uart_write_o};
            cyc_log[strobe_cnt] = cyc;
            pb_log[strobe_cnt]  = prev_busy;
         end
         strobe_cnt = strobe_cnt + 1;
         cd = rsp_delay;
      end
      if (m0_response_o) m0_rc = m0_rc + 1;
      if (m1_response_o) m1_rc = m1_rc + 1;
      prev_busy = busy_o;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit cond(input int which);
      case (which)
         0: return m0_response_o;
         1: return m1_response_o;
         2: return strobe_cnt >= strobe_tgt;
         default: return !busy_o;
      endcase
   endfunction

   task automatic wait_for(input string tag, input int which, input int maxc, output int n);
      bit ok;
      n  = 0;
      ok = cond(which);
      while (!ok && n < maxc) begin
         tick();
         n++;
         ok = cond(which);
      end
      chk(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int n, b, rc0, rc1;
      reset = 1'b1;
      m0_read_i = 0; m0_write_i = 0; m1_read_i = 0; m1_write_i = 0;
      m0_address_i = '0; m0_write_data_i = '0; m1_address_i = '0; m1_write_data_i = '0;
      rsp_delay = 2; rsp_data = '0;
      do_reset();

      // reset state
      chk("rst_grant", {30'd0, grant_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_timeout", {31'd0, timeout_err_o}, 32'd0);
      chk("rst_strobes", {30'd0, uart_read_o, uart_write_o}, 32'd0);
      chk("rst_resp", {30'd0, m0_response_o, m1_response_o}, 32'd0);

      // 1: status read
      m0_read_i = 1; m0_address_i = 32'h04; rsp_data = 32'h1; rsp_delay = 2;
      tick();
      chk("t1_uart_read", {31'd0, uart_read_o}, 32'd1);
      chk("t1_addr", uart_address_o, 32'h04);
      chk("t1_grant", {30'd0, grant_o}, 32'd1);
      tick();
      chk("t1_strobe_1cyc", {31'd0, uart_read_o}, 32'd0);
      chk("t1_addr_hold", uart_address_o, 32'h04);
      wait_for("t1_m0_resp", 0, 10, n);
      chk("t1_resp_lat", n, 2);
      chk("t1_rdata", m0_read_data_o, 32'h1);
      chk("t1_m1_resp", {31'd0, m1_response_o}, 32'd0);
      m0_read_i = 0;
      tick();
      chk("t1_resp_width", {31'd0, m0_response_o}, 32'd0);
      chk("t1_rdata_hold", m0_read_data_o, 32'h1);
      chk("t1_busy_idle", {31'd0, busy_o}, 32'd0);
      chk("t1_nstrobe", strobe_cnt, 1);
      chk("t1_m1_rc", m1_rc, 0);

      // 2: contention from reset
      do_reset();
      b = strobe_cnt; rc0 = m0_rc; rc1 = m1_rc;
      m0_write_i = 1; m0_address_i = 32'h00; m0_write_data_i = 32'hAABBCCDD;
      m1_write_i = 1; m1_address_i = 32'h08; m1_write_data_i = 32'h11223344;
      rsp_delay = 1; rsp_data = 32'h0000_0077;
      wait_for("t2_m0_resp", 0, 20, n);
      m0_write_i = 0;
      wait_for("t2_m1_resp", 1, 20, n);
      chk("t2_m1_rdata", m1_read_data_o, 32'h0000_0077);
      m1_write_i = 0;
      tick();
      chk("t2_nstrobe", strobe_cnt - b, 2);
      chk("t2_wd0", wd_log[b], 32'hAABBCCDD);
      chk("t2_wd1", wd_log[b+1], 32'h11223344);
      chk("t2_gr0", {30'd0, gr_log[b]}, 32'd1);
      chk("t2_gr1", {30'd0, gr_log[b+1]}, 32'd2);
      chk("t2_ad1", ad_log[b+1], 32'h08);
      chk("t2_m0_rc", m0_rc - rc0, 1);
      chk("t2_m1_rc", m1_rc - rc1, 1);

      // 3: fairness with continuous requests
      b = strobe_cnt;
      m0_read_i = 1; m0_address_i = 32'h0C;
      m1_read_i = 1; m1_address_i = 32'h10;
      rsp_delay = 1;
      strobe_tgt = b + 6;
      wait_for("t3_six_strobes", 2, 200, n);
      m0_read_i = 0; m1_read_i = 0;
      wait_for("t3_drain", 3, 20, n);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t3_grant%0d", i), {30'd0, gr_log[b+i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("t3_busy_before%0d", i), {31'd0, pb_log[b+i]}, 32'd0);
      end
      for (int i = 1; i < 6; i++)
         chk($sformatf("t3_gap%0d", i), {31'd0, (cyc_log[b+i] - cyc_log[b+i-1]) >= 4}, 32'd1);

      // 6: write wins over read
      b = strobe_cnt;
      m1_read_i = 1; m1_write_i = 1; m1_address_i = 32'h0C; m1_write_data_i = 32'h55;
      rsp_delay = 1;
      wait_for("t6_m1_resp", 1, 20, n);
      m1_read_i = 0; m1_write_i = 0;
      tick();
      chk("t6_nstrobe", strobe_cnt - b, 1);
      chk("t6_op", {30'd0, op_log[b]}, 32'd1);
      chk("t6_grant", {30'd0, gr_log[b]}, 32'd2);
      chk("t6_wdata", wd_log[b], 32'h55);

      // 4: watchdog with a 20-cycle peripheral
      b = strobe_cnt;
      m0_read_i = 1; m0_address_i = 32'h14; rsp_data = 32'hCAFE0001; rsp_delay = 20;
      strobe_tgt = b + 1;
      wait_for("t4_strobe", 2, 10, n);
      for (int i = 0; i < 8; i++) tick();
      chk("t4_no_timeout_yet", {31'd0, timeout_err_o}, 32'd0);
      tick();
      chk("t4_timeout_rise", {31'd0, timeout_err_o}, 32'd1);
      wait_for("t4_m0_resp", 0, 40, n);
      chk("t4_resp_cycle", n, 12);
      chk("t4_rdata", m0_read_data_o, 32'hCAFE0001);
      m0_read_i = 0;
      tick();
      chk("t4_timeout_sticky", {31'd0, timeout_err_o}, 32'd1);
      chk("t4_idle", {31'd0, busy_o}, 32'd0);

      // 5: reset while waiting on the peripheral
      b = strobe_cnt;
      m0_read_i = 1; m0_address_i = 32'h04; rsp_data = 32'hDEAD0000; rsp_delay = 6;
      strobe_tgt = b + 1;
      wait_for("t5_strobe", 2, 10, n);
      tick(); tick(); tick();
      chk("t5_busy_pre", {31'd0, busy_o}, 32'd1);
      reset = 1; m0_read_i = 0;
      tick();
      reset = 0;
      chk("t5_grant", {30'd0, grant_o}, 32'd0);
      chk("t5_busy", {31'd0, busy_o}, 32'd0);
      chk("t5_timeout", {31'd0, timeout_err_o}, 32'd0);
      chk("t5_resp", {30'd0, m0_response_o, m1_response_o}, 32'd0);
      chk("t5_rdata_clr", m0_read_data_o, 32'd0);
      rc0 = m0_rc; rc1 = m1_rc;
      for (int i = 0; i < 4; i++) tick();
      chk("t5_late_ignored_busy", {31'd0, busy_o}, 32'd0);
      chk("t5_late_ignored_rc", (m0_rc - rc0) + (m1_rc - rc1), 0);
      m1_read_i = 1; m1_address_i = 32'h18; rsp_data = 32'h00005A5A; rsp_delay = 2;
      wait_for("t5_m1_resp", 1, 20, n);
      chk("t5_m1_rdata", m1_read_data_o, 32'h00005A5A);
      chk("t5_m0_quiet", {31'd0, m0_response_o}, 32'd0);
      m1_read_i = 0;
      tick();
      chk("t5_m0_rc", m0_rc - rc0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
